decade_counter_ctrl: RTL
========================

# decade_counter_ctrl

Run controller for a chain of BCD decade counters. It drives DIGITS cascaded 0–9 up/down digits from a programmable prescaled step rate, under start/stop/clear/load commands. It sits between the board push-button/command logic and the display-digit outputs, and turns the single decade counter into a controllable multi-digit up/down counter with overflow/underflow reporting.

## Interface
Parameters:
- DIGITS, 4: number of cascaded BCD digits (1–8).
- PRESCALE, 5: clock cycles per count step (≥1).
- HALT_ON_WRAP, 0: when 1, return to IDLE after a wrap step.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle command: begin or resume counting.
- stop  in  1  single-cycle command: pause counting.
- clear  in  1  single-cycle command: zero all digits and go to IDLE.
- dir  in  1  count direction, 1 = up, 0 = down. Latched on an accepted start.
- load  in  1  single-cycle command: preset digits. Accepted in IDLE only.
- load_val  in  4*DIGITS  BCD preset, digit 0 in [3:0].
- q  out  4*DIGITS  registered BCD count, digit 0 in [3:0].
- run  out  1  high while in RUN.
- wrap  out  1  one-cycle pulse, aligned with the q update that wrapped the whole chain.

## Operation
- Reset values: q = 0, run = 0, wrap = 0, state IDLE, prescaler = 0, latched dir = 1.
- States: IDLE, RUN, PAUSE.
  - IDLE: q holds. load sets q ← load_val, with each digit >9 clamped to 9. start goes to RUN, latches dir, and sets prescaler = 0.
  - RUN: prescaler increments each cycle. When it reaches PRESCALE-1 a step occurs and the prescaler returns to 0. stop goes to PAUSE with the prescaler held. clear goes to IDLE.
  - PAUSE: q and prescaler hold. start goes to RUN, re-latches dir, and resumes from the held prescaler value. clear goes to IDLE.
- Command priority in the same cycle: clear > stop > start > load. load outside IDLE is ignored.
- clear in any state: q = 0, prescaler = 0, wrap = 0, state IDLE.
- Step rule:
  - Digit 0 always steps.
  - Digit i steps iff every lower digit is at 9 (up) or at 0 (down).
  - An up step turns 9 into 0; a down step turns 0 into 9.
  - Carry is combinational across digits, so all digits update on the same edge.
- wrap = 1 for the step cycle where all digits go from 9 to 0 (up) or from 0 to 9 (down).
- If HALT_ON_WRAP = 1, that same edge also enters IDLE (run = 0). q shows the wrapped value.
- A stop or clear coinciding with the step cycle suppresses the step. No wrap is raised.

## Timing
- start sampled at edge k: run = 1 after edge k. The first q change is at edge k+PRESCALE, and one further step follows every PRESCALE cycles.
- PRESCALE = 1: one step per cycle while in RUN.
- stop sampled at edge k: run = 0 after edge k, and q is frozen from edge k.
- Resuming from PAUSE with held prescaler value p: the next step is at edge k+PRESCALE-1-p.
- load sampled at edge k: q = clamped load_val after edge k.
- Asynchronous reset deassertion takes effect at the next clk edge. Reset asserted mid-RUN forces the reset values immediately.

## Structure
- Package decade_ctrl_pkg holds:
  - the state enum: IDLE, RUN, PAUSE.
  - BCD_MAX = 4'd9.
  - a BCD clamp function.
- Sub-module bcd_digit (clk, reset, en, up, ld, ld_val, q[3:0], term):
  - one 0–9 up/down digit.
  - term is high when q = 9 (up) or q = 0 (down).
  - instantiated DIGITS times by a generate loop, with the en chain formed from the lower digits' term signals.
- The controller holds the FSM, prescaler, dir latch and wrap register.

## Test plan
Bench parameters: DIGITS = 2, PRESCALE = 4.
- Reset, then start with dir = 1 from q = 0x00 → run = 1 next cycle; q = 0x01 at 4 cycles; q = 0x10 at 40 cycles; wrap never set.
- load 0x98 in IDLE, start up → q = 0x99 at +4; q = 0x00 with wrap = 1 for exactly one cycle at +8. Repeat with HALT_ON_WRAP = 1 → run = 0 after the wrap edge.
- load 0x3F → q = 0x39 (clamp). Start down → 0x38, …, 0x00, then 0x99 with a wrap pulse.
- Up-run: stop at prescaler = 2, idle 10 cycles, start → no q change while paused; next step exactly 1 cycle after resume.
- Same-cycle commands:
  - clear + start during RUN at q = 0x57 → q = 0x00, IDLE, run = 0.
  - stop on the step cycle → q unchanged.
  - load during RUN → ignored.
- Assert reset mid-RUN at q = 0x23 → q = 0x00, run = 0, wrap = 0 immediately. After release, start counts up from 0x00.

Source files
------------

// File: rtl/decade_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decade_ctrl_pkg
// Description : Shared types and helpers for the decade counter controller:
//               FSM state encoding, BCD digit maximum and BCD clamp function.
// Revision    : 1.0 - initial release
// ============================================================================
package decade_ctrl_pkg;

    // Controller run states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } ctrl_state_t;

    // Largest legal value of a BCD digit
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Saturate a nibble into the legal BCD range 0-9
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One 0-9 up/down BCD digit with synchronous load. term flags
//               the digit value that produces a carry/borrow to the next digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import decade_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       term
);

    logic [3:0] r_q;

    // Digit register: load has priority over a count step; wraps 9<->0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 4'd0;
        end else if (ld) begin
            r_q <= ld_val;
        end else if (en) begin
            if (up) begin
                r_q <= (r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1;
            end else begin
                r_q <= (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
            end
        end
    end

    assign q    = r_q;
    assign term = up ? (r_q == BCD_MAX) : (r_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/decade_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decade_counter_ctrl
// Description : Run controller for a chain of cascaded BCD decade counters.
//               Prescaled step rate, start/stop/clear/load commands, up/down
//               direction latch and whole-chain wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module decade_counter_ctrl
    import decade_ctrl_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 5,
    parameter int HALT_ON_WRAP = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  run,
    output logic                  wrap
);

    localparam int              c_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(PRESCALE - 1);

    ctrl_state_t         r_state;
    ctrl_state_t         w_state_nxt;
    logic [c_PW-1:0]     r_presc;
    logic [c_PW-1:0]     w_presc_nxt;
    logic                r_dir;
    logic                w_dir_nxt;
    logic                r_wrap;
    logic                w_wrap_nxt;

    logic                w_start_ok;
    logic                w_count;
    logic                w_step;
    logic                w_up;
    logic                w_ld;
    logic [4*DIGITS-1:0] w_ld_val;
    logic [DIGITS-1:0]   w_term;
    logic [DIGITS:0]     w_en;

    // start wins only when no higher-priority command is present and we are not running
    assign w_start_ok = start && !clear && !stop && (r_state != RUN);

    // The prescaler advances in RUN and also on the resume edge out of PAUSE,
    // so a held value p leads to the next step PRESCALE-1-p cycles later
    assign w_count = !clear && !stop &&
                     ((r_state == RUN) || ((r_state == PAUSE) && start));
    assign w_step  = w_count && (r_presc == c_PMAX);

    // Direction used this cycle: a freshly accepted start applies immediately
    assign w_up = w_start_ok ? dir : r_dir;

    // clear reuses the digit load path with an all-zero value
    assign w_ld = clear || ((r_state == IDLE) && load && !start && !stop);

    // Carry/borrow ripple: digit i steps only when all lower digits are terminal
    assign w_en[0] = w_step;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_ld_val[4*gi +: 4] = clear ? 4'd0 : bcd_clamp(load_val[4*gi +: 4]);
        assign w_en[gi+1]          = w_en[gi] & w_term[gi];

        bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .en     (w_en[gi]),
            .up     (w_up),
            .ld     (w_ld),
            .ld_val (w_ld_val[4*gi +: 4]),
            .q      (q[4*gi +: 4]),
            .term   (w_term[gi])
        );
    end

    // Next-state, prescaler, direction latch and wrap decode
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_dir_nxt   = r_dir;
        w_wrap_nxt  = 1'b0;

        if (clear) begin
            w_state_nxt = IDLE;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        w_state_nxt = RUN;
                        w_presc_nxt = '0;
                        w_dir_nxt   = dir;
                    end
                end
                RUN: begin
                    if (stop) begin
                        w_state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (w_start_ok) begin
                        w_state_nxt = RUN;
                        w_dir_nxt   = dir;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_presc_nxt = '0;
                end
            endcase

            if (w_count) begin
                w_presc_nxt = (r_presc == c_PMAX) ? '0 : r_presc + c_PW'(1);
            end

            // w_en[DIGITS] is high only on a step where every digit wraps
            if (w_en[DIGITS]) begin
                w_wrap_nxt = 1'b1;
                if (HALT_ON_WRAP != 0) begin
                    w_state_nxt = IDLE;
                end
            end
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_dir   <= 1'b1;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_dir   <= w_dir_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign run  = (r_state == RUN);
    assign wrap = r_wrap;

endmodule
`default_nettype wire
